// File: rtl/anf_sweep_engine.sv
// Writable M-column truth table over N inputs with an in-place Moebius (truth table <-> ANF)
// transform, a per-column degree/nonzero scan, and registered evaluation reads.
module anf_sweep_engine #(
  parameter int N  = 3,
  parameter int M  = 6,
  parameter int DW = $clog2(N+1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wr_en,
  input  logic [N-1:0]    i_wr_addr,
  input  logic [M-1:0]    i_wr_data,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  input  logic            i_eval_en,
  input  logic [N-1:0]    i_x,
  output logic [M-1:0]    o_y,
  output logic            o_y_valid,
  output logic [M*DW-1:0] o_deg,
  output logic [M-1:0]    o_nonzero
);
  localparam int D  = 1 << N;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, XFORM, SCAN} state_t;

  state_t               r_state;
  logic [M-1:0]         r_tab [D];
  logic [SW-1:0]        r_s;
  logic [N-1:0]         r_a;
  logic [M-1:0][DW-1:0] r_deg_acc, r_deg, w_deg_nxt;
  logic [M-1:0]         r_nz_acc, w_nz_nxt;
  logic [DW-1:0]        w_pop;
  logic [M-1:0]         w_word;
  logic [N-1:0]         w_bit;

  assign w_bit = N'(1) << r_s;
  assign o_deg = r_deg;

  // Running max of popcount(addr) over the nonzero entries seen so far, per column.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) w_pop = w_pop + DW'(r_a[i]);
    w_word    = r_tab[r_a];
    w_deg_nxt = r_deg_acc;
    w_nz_nxt  = r_nz_acc;
    for (int j = 0; j < M; j++) begin
      if (w_word[j]) begin
        w_nz_nxt[j] = 1'b1;
        if (w_pop > r_deg_acc[j]) w_deg_nxt[j] = w_pop;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_s       <= '0;
      r_a       <= '0;
      r_deg_acc <= '0;
      r_nz_acc  <= '0;
      r_deg     <= '0;
      o_nonzero <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_y       <= '0;
      o_y_valid <= 1'b0;
      for (int a = 0; a < D; a++) r_tab[a] <= '0;
    end else begin
      o_done    <= 1'b0;
      o_y_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_wr_en) r_tab[i_wr_addr] <= i_wr_data;
          if (i_eval_en) begin
            o_y       <= r_tab[i_x];
            o_y_valid <= 1'b1;
          end
          if (i_start) begin
            r_state <= XFORM;
            r_s     <= '0;
            o_busy  <= 1'b1;
          end
        end
        XFORM: begin
          // Butterfly on bit s: upper half of each pair absorbs its lower partner.
          for (int a = 0; a < D; a++)
            if ((N'(a) & w_bit) != '0) r_tab[a] <= r_tab[a] ^ r_tab[N'(a) ^ w_bit];
          if (r_s == SW'(N-1)) begin
            r_state   <= SCAN;
            r_a       <= '0;
            r_deg_acc <= '0;
            r_nz_acc  <= '0;
          end else begin
            r_s <= r_s + SW'(1);
          end
        end
        SCAN: begin
          r_deg_acc <= w_deg_nxt;
          r_nz_acc  <= w_nz_nxt;
          if (r_a == N'(D-1)) begin
            r_deg     <= w_deg_nxt;
            o_nonzero <= w_nz_nxt;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_a <= r_a + N'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_anf_sweep_engine.sv
// Directed bench for anf_sweep_engine (N=3, M=6): load, transform, involution, busy drops,
// mid-run reset and same-cycle write+start.
module tb_anf_sweep_engine;
  logic        clk, rst, wr_en, start, eval_en;
  logic [2:0]  wr_addr, x;
  logic [5:0]  wr_data, y, nonzero;
  logic        busy, done, y_valid;
  logic [11:0] deg;
  int checks = 0;
  int failures = 0;

  anf_sweep_engine #(.N(3), .M(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_start(start), .o_busy(busy), .o_done(done), .i_eval_en(eval_en), .i_x(x),
    .o_y(y), .o_y_valid(y_valid), .o_deg(deg), .o_nonzero(nonzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [5:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic ev(input logic [2:0] a, input logic [5:0] e, input string tag);
    eval_en = 1'b1; x = a;
    @(posedge clk); #1;
    eval_en = 1'b0;
    chk({tag, "_y"}, y, e);
    chk({tag, "_vld"}, y_valid, 1);
  endtask

  // Issues start (plus any write already on the bus), measures done latency and busy length.
  task automatic run(input bit disturb, input logic [11:0] edeg, input logic [5:0] enz,
                     input string tag);
    int cyc, bcnt;
    logic [5:0] y0;
    y0 = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    cyc = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      if (disturb && cyc == 2) begin
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 6'h3F;
        eval_en = 1'b1; x = 3'd5; start = 1'b1;
      end
      @(posedge clk); #1;
      if (disturb && cyc == 2) chk({tag, "_busy_no_yvld"}, y_valid, 0);
      wr_en = 1'b0; eval_en = 1'b0; start = 1'b0;
      cyc++;
      if (busy) bcnt++;
    end
    chk({tag, "_done_lat"}, cyc, 11);
    chk({tag, "_busy_len"}, bcnt, 11);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_deg"}, deg, edeg);
    chk({tag, "_nz"}, nonzero, enz);
    chk({tag, "_y_hold"}, y, y0);
    @(posedge clk); #1;
    chk({tag, "_done_fall"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; start = 0; eval_en = 0; wr_addr = 0; wr_data = 0; x = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y", y, 0);
    chk("rst_yvld", y_valid, 0);
    chk("rst_deg", deg, 0);
    chk("rst_nz", nonzero, 0);
    rst = 1'b0;

    // Truth table of y0..y5 (bit j = function j)
    wr(0, 6'h3E); wr(1, 6'h3D); wr(2, 6'h3B); wr(3, 6'h37);
    wr(4, 6'h2F); wr(5, 6'h1F); wr(6, 6'h2B); wr(7, 6'h17);
    ev(2, 6'h3B, "load_rd2");
    chk("yvld_fall", y_valid, 1);
    @(posedge clk); #1;
    chk("yvld_fall", y_valid, 0);

    // Same-cycle write+eval to one address returns the old word
    wr_en = 1'b1; wr_addr = 0; wr_data = 6'h00; eval_en = 1'b1; x = 0;
    @(posedge clk); #1;
    wr_en = 1'b0; eval_en = 1'b0;
    chk("rbw_old", y, 6'h3E);
    ev(0, 6'h00, "rbw_new");
    wr(0, 6'h3E);

    run(0, 12'hAAF, 6'h3F, "anf1");
    ev(0, 6'h3E, "anf_a0");
    ev(3, 6'h0F, "anf_a3");
    ev(5, 6'h33, "anf_a5");
    ev(6, 6'h01, "anf_a6");

    // Second pass restores the truth table; disturbances while busy must be dropped
    run(1, 12'hBBF, 6'h3F, "inv");
    ev(0, 6'h3E, "tt0"); ev(1, 6'h3D, "tt1"); ev(2, 6'h3B, "tt2"); ev(3, 6'h37, "tt3");
    ev(4, 6'h2F, "tt4"); ev(5, 6'h1F, "tt5"); ev(6, 6'h2B, "tt6"); ev(7, 6'h17, "tt7");

    // Reset in the 4th busy cycle
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_y", y, 0);
    chk("mrst_deg", deg, 0);
    chk("mrst_nz", nonzero, 0);
    ev(3, 6'h00, "mrst_a3");
    ev(7, 6'h00, "mrst_a7");

    run(0, 12'h000, 6'h00, "zero");

    // Minterm at 000 expands to every monomial
    wr(0, 6'h3F);
    run(0, 12'hFFF, 6'h3F, "min0");
    ev(5, 6'h3F, "min0_a5");
    ev(7, 6'h3F, "min0_a7");

    // Write and start in one cycle: minterm x0x1x2 is its own single ANF monomial
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 6'h01;
    run(0, 12'h003, 6'h01, "wrst");
    ev(7, 6'h01, "wrst_a7");
    ev(0, 6'h00, "wrst_a0");
    ev(3, 6'h00, "wrst_a3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
